fft32_seq_ctrl: RTL and testbench

Sequencing controller for the 32-point radix-2 DIT FFT datapath. It loads 32 samples into the working memory in bit-reversed order and schedules 5 stages of 16 butterflies each. For every butterfly it generates read, write and twiddle addresses plus the operand mux select. It then unloads the results in natural order. The block holds no sample data; it drives the memory, the twiddle ROM, the butterfly pipeline and the 4x1 operand mux.

---
 rtl/fft32_seq_ctrl_if.sv | 37 +++
 rtl/fft32_seq_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_fft32_seq_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft32_seq_ctrl_if.sv
// Handshake and memory/datapath control bundle for the 32-point FFT sequencer.
// The controller uses the master view; the datapath (or a bench) uses the slave view.
interface fft32_seq_ctrl_if #(
   parameter int addr_width = 5
);
   logic                  start;
   logic                  in_valid;
   logic                  in_ready;
   logic                  out_ready;
   logic                  out_valid;
   logic                  rd_en;
   logic [addr_width-1:0] rd_addr_a;
   logic [addr_width-1:0] rd_addr_b;
   logic                  wr_en;
   logic [addr_width-1:0] wr_addr_a;
   logic [addr_width-1:0] wr_addr_b;
   logic                  wr_b_en;
   logic [addr_width-2:0] tw_addr;
   logic [1:0]            mux_sel;
   logic [2:0]            stage;
   logic                  busy;
   logic                  done;

   modport master (
      input  start, in_valid, out_ready,
      output in_ready, out_valid, rd_en, rd_addr_a, rd_addr_b,
             wr_en, wr_addr_a, wr_addr_b, wr_b_en, tw_addr,
             mux_sel, stage, busy, done
   );

   modport slave (
      output start, in_valid, out_ready,
      input  in_ready, out_valid, rd_en, rd_addr_a, rd_addr_b,
             wr_en, wr_addr_a, wr_addr_b, wr_b_en, tw_addr,
             mux_sel, stage, busy, done
   );
endinterface

// File: rtl/fft32_seq_ctrl.sv
// Sequencing controller for a 32-point radix-2 DIT FFT: bit-reversed load,
// 5 in-place butterfly stages with delayed writeback, natural-order unload.
module fft32_seq_ctrl #(
   parameter int addr_width = 5,
   parameter int bf_latency = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   fft32_seq_ctrl_if.master bus
);

   localparam int PIPE       = bf_latency + 1;
   localparam int CW         = (PIPE > 1) ? $clog2(PIPE) : 1;
   localparam int BW         = addr_width - 1;
   localparam int TW         = addr_width - 1;
   localparam int LAST_STAGE = addr_width - 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_COMPUTE,
      S_DRAIN,
      S_UNLOAD
   } state_t;

   state_t                          state_q, state_d;
   logic [addr_width-1:0]           n_q, n_d;
   logic [BW-1:0]                   b_q, b_d;
   logic [2:0]                      stage_q, stage_d;
   logic [CW-1:0]                   drain_q, drain_d;
   logic                            last_q, last_d;
   logic                            out_valid_q, out_valid_d;
   logic                            done_q, done_d;
   logic [PIPE-1:0]                 pipe_vld_q, pipe_vld_d;
   logic [PIPE-1:0][addr_width-1:0] pipe_a_q, pipe_a_d;
   logic [PIPE-1:0][addr_width-1:0] pipe_b_q, pipe_b_d;

   logic [addr_width-1:0] b_ext, span, grp, idx, bf_a, bf_b;
   logic [TW-1:0]         bf_tw;

   function automatic logic [addr_width-1:0] bitrev(input logic [addr_width-1:0] v);
      logic [addr_width-1:0] r;
      for (int i = 0; i < addr_width; i++) begin
         r[i] = v[addr_width-1-i];
      end
      return r;
   endfunction

   // Butterfly operand and twiddle addresses for the current stage and butterfly index.
   always_comb begin
      b_ext = addr_width'(b_q);
      span  = addr_width'(1) << stage_q;
      grp   = b_ext >> stage_q;
      idx   = b_ext & (span - addr_width'(1));
      bf_a  = (grp << (stage_q + 3'd1)) | idx;
      bf_b  = bf_a + span;
      bf_tw = TW'(idx << (3'(TW) - stage_q));
   end

   // Next-state, counters, writeback delay line and all datapath control outputs.
   always_comb begin
      state_d     = state_q;
      n_d         = n_q;
      b_d         = b_q;
      stage_d     = stage_q;
      drain_d     = drain_q;
      last_d      = last_q;
      out_valid_d = 1'b0;
      done_d      = 1'b0;

      pipe_vld_d  = '0;
      pipe_a_d    = '0;
      pipe_b_d    = '0;
      for (int i = 1; i < PIPE; i++) begin
         pipe_vld_d[i] = pipe_vld_q[i-1];
         pipe_a_d[i]   = pipe_a_q[i-1];
         pipe_b_d[i]   = pipe_b_q[i-1];
      end
      pipe_a_d[0] = bf_a;
      pipe_b_d[0] = bf_b;

      bus.in_ready  = 1'b0;
      bus.rd_en     = 1'b0;
      bus.rd_addr_a = '0;
      bus.rd_addr_b = '0;
      bus.wr_en     = 1'b0;
      bus.wr_b_en   = 1'b0;
      bus.wr_addr_a = '0;
      bus.wr_addr_b = '0;
      bus.tw_addr   = '0;
      bus.mux_sel   = 2'b11;
      bus.busy      = (state_q != S_IDLE);
      bus.done      = done_q;
      bus.out_valid = out_valid_q;
      bus.stage     = stage_q;

      case (state_q)
         S_IDLE: begin
            if (bus.start && !done_q) begin
               state_d = S_LOAD;
               n_d     = '0;
               b_d     = '0;
               stage_d = '0;
            end
         end
         S_LOAD: begin
            bus.in_ready = 1'b1;
            bus.mux_sel  = 2'b00;
            if (bus.in_valid) begin
               bus.wr_en     = 1'b1;
               bus.wr_addr_a = bitrev(n_q);
               n_d           = n_q + addr_width'(1);
               if (n_q == '1) begin
                  state_d = S_COMPUTE;
                  stage_d = '0;
                  b_d     = '0;
               end
            end
         end
         S_COMPUTE: begin
            bus.rd_en     = 1'b1;
            bus.mux_sel   = 2'b01;
            bus.rd_addr_a = bf_a;
            bus.rd_addr_b = bf_b;
            bus.tw_addr   = bf_tw;
            pipe_vld_d[0] = 1'b1;
            if (b_q == '1) begin
               state_d = S_DRAIN;
               drain_d = '0;
               b_d     = '0;
            end else begin
               b_d = b_q + BW'(1);
            end
         end
         S_DRAIN: begin
            if (drain_q == CW'(PIPE - 1)) begin
               if (stage_q == 3'(LAST_STAGE)) begin
                  state_d = S_UNLOAD;
                  n_d     = '0;
                  last_d  = 1'b0;
               end else begin
                  state_d = S_COMPUTE;
                  stage_d = stage_q + 3'd1;
                  b_d     = '0;
               end
            end else begin
               drain_d = drain_q + CW'(1);
            end
         end
         S_UNLOAD: begin
            if (last_q) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
               last_d  = 1'b0;
            end else if (bus.out_ready) begin
               bus.rd_en     = 1'b1;
               bus.rd_addr_a = n_q;
               out_valid_d   = 1'b1;
               n_d           = n_q + addr_width'(1);
               if (n_q == '1) begin
                  last_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (pipe_vld_q[PIPE-1]) begin
         bus.wr_en     = 1'b1;
         bus.wr_b_en   = 1'b1;
         bus.wr_addr_a = pipe_a_q[PIPE-1];
         bus.wr_addr_b = pipe_b_q[PIPE-1];
         bus.mux_sel   = 2'b10;
      end
   end

   // State register; reset drops the delay line so in-flight writebacks never land.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         n_q         <= '0;
         b_q         <= '0;
         stage_q     <= '0;
         drain_q     <= '0;
         last_q      <= 1'b0;
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
         pipe_vld_q  <= '0;
         pipe_a_q    <= '0;
         pipe_b_q    <= '0;
      end else begin
         state_q     <= state_d;
         n_q         <= n_d;
         b_q         <= b_d;
         stage_q     <= stage_d;
         drain_q     <= drain_d;
         last_q      <= last_d;
         out_valid_q <= out_valid_d;
         done_q      <= done_d;
         pipe_vld_q  <= pipe_vld_d;
         pipe_a_q    <= pipe_a_d;
         pipe_b_q    <= pipe_b_d;
      end
   end

endmodule

// File: tb/tb_fft32_seq_ctrl.sv
// Self-checking bench for fft32_seq_ctrl: scoreboard queues hold expected load
// addresses, writeback pairs and unload addresses, checked as the DUT produces them.
module tb_fft32_seq_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   int load_q[$];
   int wb_a_q[$];
   int wb_b_q[$];
   int wb_due_q[$];
   int ov_addr_q[$];
   int ov_due_q[$];

   fft32_seq_ctrl_if #(.addr_width(5)) bus();

   fft32_seq_ctrl #(
      .addr_width(5),
      .bf_latency(3)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   // Absolute bound on simulation time.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic int bitrev_model(input int k);
      int r;
      int v;
      r = 0;
      v = k;
      for (int i = 0; i < 5; i++) begin
         r = r * 2 + (v % 2);
         v = v / 2;
      end
      return r;
   endfunction

   task automatic test_reset();
      logic [35:0] obs;
      logic [35:0] exp_v;
      exp_v = {7'b0, 20'b0, 4'b0, 2'b11, 3'b0};
      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      #1;
      obs = {bus.in_ready, bus.out_valid, bus.rd_en, bus.wr_en, bus.wr_b_en, bus.busy, bus.done,
             bus.rd_addr_a, bus.rd_addr_b, bus.wr_addr_a, bus.wr_addr_b, bus.tw_addr, bus.mux_sel, bus.stage};
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("[TB] FAIL reset_immediate: got %h expected %h", obs, exp_v);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      obs = {bus.in_ready, bus.out_valid, bus.rd_en, bus.wr_en, bus.wr_b_en, bus.busy, bus.done,
             bus.rd_addr_a, bus.rd_addr_b, bus.wr_addr_a, bus.wr_addr_b, bus.tw_addr, bus.mux_sel, bus.stage};
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("[TB] FAIL reset_held: got %h expected %h", obs, exp_v);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         checks++;
         if (bus.wr_en !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_quiet: got wr_en=%b busy=%b expected 0 0", bus.wr_en, bus.busy);
         end
      end
      load_q.delete();
      wb_a_q.delete();
      wb_b_q.delete();
      wb_due_q.delete();
      ov_addr_q.delete();
      ov_due_q.delete();
      @(posedge clk);
      #1;
   endtask

   task automatic test_load(input bit gaps);
      int k;
      int wr_count;
      int guard;
      int exp_a;
      k = 0;
      wr_count = 0;
      guard = 0;
      bus.start = 1'b1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL idle_before_start: got busy=%b in_ready=%b done=%b expected 0 0 0",
                  bus.busy, bus.in_ready, bus.done);
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      while (k < 32 && guard < 100) begin
         bus.in_valid = (gaps && (guard % 4 == 3)) ? 1'b0 : 1'b1;
         if (bus.in_valid) load_q.push_back(bitrev_model(k));
         @(negedge clk);
         checks++;
         if (bus.in_ready !== 1'b1 || bus.mux_sel !== 2'b00 || bus.busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL load_status: got in_ready=%b mux_sel=%b busy=%b expected 1 00 1",
                     bus.in_ready, bus.mux_sel, bus.busy);
         end
         checks++;
         if (bus.wr_en !== bus.in_valid) begin
            errors++;
            $display("[TB] FAIL load_wr_en: got %b expected %b (sample %0d)", bus.wr_en, bus.in_valid, k);
         end
         if (bus.wr_en === 1'b1 && load_q.size() > 0) begin
            wr_count++;
            exp_a = load_q.pop_front();
            checks++;
            if (bus.wr_addr_a !== 5'(exp_a) || bus.wr_b_en !== 1'b0) begin
               errors++;
               $display("[TB] FAIL load_addr: got addr=%0d wr_b_en=%b expected %0d 0",
                        bus.wr_addr_a, bus.wr_b_en, exp_a);
            end
         end
         if (bus.in_valid) k++;
         @(posedge clk);
         #1;
         guard++;
      end
      bus.in_valid = 1'b0;
      load_q.delete();
      checks++;
      if (wr_count != 32) begin
         errors++;
         $display("[TB] FAIL load_write_count: got %0d expected 32", wr_count);
      end
   endtask

   task automatic test_compute(input bit abort, input int ab_stage, input int ab_b);
      int s, pos, span, g, j, ea, eb, et, wa, wb;
      for (int c = 0; c < 100; c++) begin
         s = c / 20;
         pos = c % 20;
         bus.start = (c == 30) ? 1'b1 : 1'b0;
         @(negedge clk);
         checks++;
         if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0 || bus.stage !== 3'(s)) begin
            errors++;
            $display("[TB] FAIL compute_status c%0d: got busy=%b in_ready=%b stage=%0d expected 1 0 %0d",
                     c, bus.busy, bus.in_ready, bus.stage, s);
         end
         if (pos < 16) begin
            span = 1 << s;
            g = pos / span;
            j = pos % span;
            ea = g * 2 * span + j;
            eb = ea + span;
            et = j * (16 / span);
            checks++;
            if (bus.rd_en !== 1'b1 || bus.rd_addr_a !== 5'(ea) || bus.rd_addr_b !== 5'(eb) ||
                bus.tw_addr !== 4'(et)) begin
               errors++;
               $display("[TB] FAIL bf_issue s%0d b%0d: got rd_en=%b a=%0d b=%0d tw=%0d expected 1 %0d %0d %0d",
                        s, pos, bus.rd_en, bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr, ea, eb, et);
            end
            wb_a_q.push_back(ea);
            wb_b_q.push_back(eb);
            wb_due_q.push_back(c + 4);
         end else begin
            checks++;
            if (bus.rd_en !== 1'b0) begin
               errors++;
               $display("[TB] FAIL drain_rd_en c%0d: got %b expected 0", c, bus.rd_en);
            end
         end
         if (wb_due_q.size() > 0 && wb_due_q[0] == c) begin
            wa = wb_a_q.pop_front();
            wb = wb_b_q.pop_front();
            void'(wb_due_q.pop_front());
            checks++;
            if (bus.wr_en !== 1'b1 || bus.wr_b_en !== 1'b1 || bus.wr_addr_a !== 5'(wa) ||
                bus.wr_addr_b !== 5'(wb) || bus.mux_sel !== 2'b10) begin
               errors++;
               $display("[TB] FAIL writeback c%0d: got wr=%b wrb=%b a=%0d b=%0d mux=%b expected 1 1 %0d %0d 10",
                        c, bus.wr_en, bus.wr_b_en, bus.wr_addr_a, bus.wr_addr_b, bus.mux_sel, wa, wb);
            end
         end else begin
            checks++;
            if (bus.wr_en !== 1'b0 || bus.mux_sel !== 2'b01) begin
               errors++;
               $display("[TB] FAIL no_writeback c%0d: got wr_en=%b mux=%b expected 0 01",
                        c, bus.wr_en, bus.mux_sel);
            end
         end
         if (abort && s == ab_stage && pos == ab_b) begin
            bus.start = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
      end
      bus.start = 1'b0;
      checks++;
      if (wb_due_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL writeback_outstanding: got %0d pending expected 0", wb_due_q.size());
      end
   endtask

   task automatic test_unload(input bit toggle);
      int issued;
      int ov_count;
      int u;
      int exp_done;
      bit seen;
      issued = 0;
      ov_count = 0;
      u = 0;
      seen = 1'b0;
      exp_done = toggle ? 64 : 33;
      while (u < 100 && !seen) begin
         bus.out_ready = toggle ? ((u % 2) == 0) : 1'b1;
         @(negedge clk);
         if (issued < 32 && bus.out_ready) begin
            checks++;
            if (bus.rd_en !== 1'b1 || bus.rd_addr_a !== 5'(issued)) begin
               errors++;
               $display("[TB] FAIL unload_issue u%0d: got rd_en=%b addr=%0d expected 1 %0d",
                        u, bus.rd_en, bus.rd_addr_a, issued);
            end
            ov_addr_q.push_back(issued);
            ov_due_q.push_back(u + 1);
            issued++;
         end else begin
            checks++;
            if (bus.rd_en !== 1'b0) begin
               errors++;
               $display("[TB] FAIL unload_paused u%0d: got rd_en=%b expected 0", u, bus.rd_en);
            end
         end
         checks++;
         if (bus.wr_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL unload_no_write u%0d: got wr_en=%b expected 0", u, bus.wr_en);
         end
         if (ov_due_q.size() > 0 && ov_due_q[0] == u) begin
            void'(ov_due_q.pop_front());
            void'(ov_addr_q.pop_front());
            checks++;
            if (bus.out_valid !== 1'b1) begin
               errors++;
               $display("[TB] FAIL out_valid_timing u%0d: got %b expected 1", u, bus.out_valid);
            end else begin
               ov_count++;
            end
         end else begin
            checks++;
            if (bus.out_valid !== 1'b0) begin
               errors++;
               $display("[TB] FAIL out_valid_spurious u%0d: got %b expected 0", u, bus.out_valid);
            end
         end
         if (bus.done === 1'b1) begin
            seen = 1'b1;
            checks++;
            if (bus.busy !== 1'b0 || u != exp_done) begin
               errors++;
               $display("[TB] FAIL done_timing: got busy=%b cycle=%0d expected 0 %0d", bus.busy, u, exp_done);
            end
            checks++;
            if (issued != 32 || ov_count != 32) begin
               errors++;
               $display("[TB] FAIL unload_counts: got issued=%0d out_valid=%0d expected 32 32", issued, ov_count);
            end
            bus.start = 1'b1;
         end else begin
            checks++;
            if (bus.busy !== 1'b1) begin
               errors++;
               $display("[TB] FAIL busy_before_done u%0d: got %b expected 1", u, bus.busy);
            end
            @(posedge clk);
            #1;
            u++;
         end
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("[TB] FAIL done_timeout: got no done within 100 cycles expected done at %0d", exp_done);
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.out_ready = 1'b0;
      ov_addr_q.delete();
      ov_due_q.delete();
   endtask

   task automatic test_full_transform();
      test_load(1'b1);
      test_compute(1'b0, 0, 0);
      test_unload(1'b0);
   endtask

   task automatic test_back_to_back();
      test_load(1'b0);
      test_compute(1'b0, 0, 0);
      test_unload(1'b1);
   endtask

   task automatic test_reset_mid_compute();
      test_load(1'b0);
      test_compute(1'b1, 2, 7);
      test_reset();
      test_load(1'b0);
      test_compute(1'b0, 0, 0);
      test_unload(1'b0);
   endtask

   // Test sequence.
   initial begin
      bus.start = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      $display("[TB] reset checks");
      test_reset();
      $display("[TB] full transform with input gaps");
      test_full_transform();
      $display("[TB] back-to-back transform with unload pauses");
      test_back_to_back();
      $display("[TB] reset during compute");
      test_reset_mid_compute();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
